// File: rtl/ascon_out_unpack_pkg.sv
// Shared Ascon datapath constants and the output-unpacker state encoding.
// Imported by the unpacker interface, top and tag comparator.
package ascon_pack;

  localparam int BLOCK_WIDTH = 128;
  localparam int PAD_AW      = 4;
  localparam int BLOCK_BYTES = BLOCK_WIDTH / 8;
  localparam int OUT_WIDTH   = 32;
  localparam int OUT_WORDS   = BLOCK_WIDTH / OUT_WIDTH;
  localparam int OUT_BYTES   = OUT_WIDTH / 8;

  typedef enum logic [1:0] {
    UnpIdle,
    UnpData,
    UnpWaitTag,
    UnpTagOut
  } unpack_state_e;

endpackage

// File: rtl/ascon_out_unpack_if.sv
// Bundle of block-in, tag-in and word-out handshakes for ascon_out_unpack.
// slave = unpacker side, master = core/FIFO side.
interface ascon_out_unpack_if;
  import ascon_pack::*;

  logic                   blk_valid_i;
  logic                   blk_ready_o;
  logic [BLOCK_WIDTH-1:0] blk_data_i;
  logic [PAD_AW:0]        blk_bytes_i;
  logic                   blk_last_i;
  logic                   dec_mode_i;
  logic                   tag_valid_i;
  logic                   tag_ready_o;
  logic [BLOCK_WIDTH-1:0] tag_i;
  logic [BLOCK_WIDTH-1:0] exp_tag_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [OUT_WIDTH-1:0]   out_data_o;
  logic [OUT_BYTES-1:0]   out_strb_o;
  logic                   out_last_o;
  logic                   done_o;
  logic                   tag_ok_o;

  modport slave (
    input  blk_valid_i, blk_data_i, blk_bytes_i,
    input  blk_last_i, dec_mode_i,
    input  tag_valid_i, tag_i, exp_tag_i,
    input  out_ready_i,
    output blk_ready_o, tag_ready_o,
    output out_valid_o, out_data_o, out_strb_o,
    output out_last_o, done_o, tag_ok_o
  );

  modport master (
    output blk_valid_i, blk_data_i, blk_bytes_i,
    output blk_last_i, dec_mode_i,
    output tag_valid_i, tag_i, exp_tag_i,
    output out_ready_i,
    input  blk_ready_o, tag_ready_o,
    input  out_valid_o, out_data_o, out_strb_o,
    input  out_last_o, done_o, tag_ok_o
  );

endinterface

// File: rtl/ascon_out_unpack_tag_cmp.sv
// Constant-time tag equality: XOR every bit, OR-reduce, no early exit.
// Ports: a_i, b_i (tags), eq_o (1 when identical).
module ascon_tag_cmp
  import ascon_pack::*;
(
  input  logic [BLOCK_WIDTH-1:0] a_i,
  input  logic [BLOCK_WIDTH-1:0] b_i,
  output logic                   eq_o
);

  assign eq_o = ~|(a_i ^ b_i);

endmodule

// File: rtl/ascon_out_unpack.sv
// Strips block padding, serialises 128-bit blocks to 32-bit strobed words,
// appends the tag (encrypt) or checks it (decrypt). Ports: clk_i, rst_i, bus.
module ascon_out_unpack
  import ascon_pack::*;
#(
  parameter int BLOCK_W = BLOCK_WIDTH,
  parameter int OUT_W   = OUT_WIDTH,
  parameter int BYTES_W = PAD_AW + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ascon_out_unpack_if.slave   bus
);

  localparam logic [BYTES_W-1:0] MaxBytes = BYTES_W'(BLOCK_BYTES);

  unpack_state_e                       state_q, state_d;
  logic [OUT_WORDS-1:0][OUT_W-1:0]     buf_q, buf_d;
  logic [BYTES_W-1:0]                  bytes_q, bytes_d;
  logic [1:0]                          widx_q, widx_d;
  logic                                last_q, last_d;
  logic                                dec_q, dec_d;
  logic                                tag_ok_q, tag_ok_d;
  logic                                done_q, done_d;

  logic [BYTES_W-1:0] bytes_c;
  logic [BYTES_W-1:0] rem;
  logic [OUT_W-1:0]   word;
  logic [3:0]         strb;
  logic               tag_eq;
  logic               out_hs;
  logic               fin_word;

  ascon_tag_cmp u_cmp (
    .a_i  (bus.tag_i),
    .b_i  (bus.exp_tag_i),
    .eq_o (tag_eq)
  );

  assign bytes_c = (bus.blk_bytes_i > MaxBytes)
                 ? MaxBytes : bus.blk_bytes_i;

  // Bytes still to send, counting the current word.
  assign rem      = bytes_q - {1'b0, widx_q, 2'b00};
  assign fin_word = (rem <= 5'd4);

  // Word k lives in the top of the buffer: index 3-k.
  assign word = buf_q[~widx_q];

  always_comb begin
    strb = 4'b0000;
    if (state_q == UnpTagOut) begin
      strb = 4'b1111;
    end else if (state_q == UnpData) begin
      unique case (1'b1)
        (rem >= 5'd4): strb = 4'b1111;
        (rem == 5'd3): strb = 4'b1110;
        (rem == 5'd2): strb = 4'b1100;
        (rem == 5'd1): strb = 4'b1000;
        default:       strb = 4'b0000;
      endcase
    end
  end

  always_comb begin
    bus.out_data_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) bus.out_data_o[8*i +: 8] = word[8*i +: 8];
    end
  end

  assign bus.out_valid_o = (state_q == UnpData)
                        || (state_q == UnpTagOut);
  assign bus.out_strb_o  = strb;
  assign bus.out_last_o  =
      ((state_q == UnpData) && fin_word && last_q && dec_q)
   || ((state_q == UnpTagOut) && (widx_q == 2'd3));
  assign bus.blk_ready_o = (state_q == UnpIdle);
  assign bus.tag_ready_o = (state_q == UnpWaitTag);
  assign bus.done_o      = done_q;
  assign bus.tag_ok_o    = tag_ok_q;

  assign out_hs = bus.out_valid_o & bus.out_ready_i;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    bytes_d  = bytes_q;
    widx_d   = widx_q;
    last_d   = last_q;
    dec_d    = dec_q;
    tag_ok_d = tag_ok_q;
    done_d   = 1'b0;
    unique case (state_q)
      UnpIdle: begin
        if (bus.blk_valid_i) begin
          buf_d    = bus.blk_data_i;
          bytes_d  = bytes_c;
          last_d   = bus.blk_last_i;
          dec_d    = bus.dec_mode_i;
          tag_ok_d = 1'b0;
          widx_d   = 2'd0;
          if (bytes_c != '0)         state_d = UnpData;
          else if (bus.blk_last_i)   state_d = UnpWaitTag;
        end
      end
      UnpData: begin
        if (out_hs) begin
          if (fin_word) state_d = last_q ? UnpWaitTag : UnpIdle;
          else          widx_d  = widx_q + 2'd1;
        end
      end
      UnpWaitTag: begin
        if (bus.tag_valid_i) begin
          if (dec_q) begin
            tag_ok_d = tag_eq;
            done_d   = 1'b1;
            state_d  = UnpIdle;
          end else begin
            // Tag reuses the block buffer for serialisation.
            buf_d   = bus.tag_i;
            widx_d  = 2'd0;
            state_d = UnpTagOut;
          end
        end
      end
      UnpTagOut: begin
        if (out_hs) begin
          if (widx_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = UnpIdle;
          end else begin
            widx_d = widx_q + 2'd1;
          end
        end
      end
      default: state_d = UnpIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= UnpIdle;
      buf_q    <= '0;
      bytes_q  <= '0;
      widx_q   <= 2'd0;
      last_q   <= 1'b0;
      dec_q    <= 1'b0;
      tag_ok_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      bytes_q  <= bytes_d;
      widx_q   <= widx_d;
      last_q   <= last_d;
      dec_q    <= dec_d;
      tag_ok_q <= tag_ok_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_ascon_out_unpack.sv
// Directed bench for ascon_out_unpack: encrypt/decrypt streams, stalls,
// clamping, empty blocks and mid-message reset.
module tb_ascon_out_unpack;
  import ascon_pack::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  ascon_out_unpack_if bus ();

  ascon_out_unpack dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_blk(input logic [127:0] d, input logic [4:0] n,
                          input logic l, input logic dm);
    int k = 0;
    while (!bus.blk_ready_o && k < 40) begin step(); k++; end
    chk("blk_ready timeout", bus.blk_ready_o, 1'b1);
    bus.blk_valid_i = 1'b1;
    bus.blk_data_i  = d;
    bus.blk_bytes_i = n;
    bus.blk_last_i  = l;
    bus.dec_mode_i  = dm;
    step();
    bus.blk_valid_i = 1'b0;
  endtask

  task automatic send_tag(input logic [127:0] t, input logic [127:0] e);
    int k = 0;
    while (!bus.tag_ready_o && k < 40) begin step(); k++; end
    chk("tag_ready timeout", bus.tag_ready_o, 1'b1);
    bus.tag_valid_i = 1'b1;
    bus.tag_i       = t;
    bus.exp_tag_i   = e;
    step();
    bus.tag_valid_i = 1'b0;
  endtask

  task automatic get_word(input string nm, input logic [31:0] d,
                          input logic [3:0] s, input logic l,
                          input int stall);
    int k = 0;
    bus.out_ready_i = 1'b0;
    while (!bus.out_valid_o && k < 40) begin step(); k++; end
    chk({nm, " valid"}, bus.out_valid_o, 1'b1);
    for (int i = 0; i < stall; i++) begin
      step();
      chk({nm, " stall valid"}, bus.out_valid_o, 1'b1);
      chk({nm, " stall data"}, bus.out_data_o, d);
      chk({nm, " stall strb"}, bus.out_strb_o, s);
      chk({nm, " stall blk_ready"}, bus.blk_ready_o, 1'b0);
    end
    chk({nm, " data"}, bus.out_data_o, d);
    chk({nm, " strb"}, bus.out_strb_o, s);
    chk({nm, " last"}, bus.out_last_o, l);
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
  endtask

  logic [127:0] tag_a;
  logic [127:0] tag_b;

  initial begin
    bus.blk_valid_i = 1'b0;
    bus.blk_data_i  = '0;
    bus.blk_bytes_i = '0;
    bus.blk_last_i  = 1'b0;
    bus.dec_mode_i  = 1'b0;
    bus.tag_valid_i = 1'b0;
    bus.tag_i       = '0;
    bus.exp_tag_i   = '0;
    bus.out_ready_i = 1'b0;
    tag_a = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    tag_b = 128'h0123456789abcdeffedcba9876543210;

    step(); step();
    rst = 1'b0;
    chk("rst blk_ready", bus.blk_ready_o, 1'b1);
    chk("rst tag_ready", bus.tag_ready_o, 1'b0);
    chk("rst out_valid", bus.out_valid_o, 1'b0);
    chk("rst out_data", bus.out_data_o, 32'h0);
    chk("rst out_strb", bus.out_strb_o, 4'h0);
    chk("rst out_last", bus.out_last_o, 1'b0);
    chk("rst done", bus.done_o, 1'b0);
    chk("rst tag_ok", bus.tag_ok_o, 1'b0);

    // Encrypt, one full last block, then tag words.
    send_blk(128'h000102030405060708090a0b0c0d0e0f, 5'd16, 1'b1, 1'b0);
    chk("enc latency valid", bus.out_valid_o, 1'b1);
    chk("enc blk_ready low", bus.blk_ready_o, 1'b0);
    get_word("enc w0", 32'h00010203, 4'hf, 1'b0, 0);
    get_word("enc w1", 32'h04050607, 4'hf, 1'b0, 0);
    get_word("enc w2", 32'h08090a0b, 4'hf, 1'b0, 0);
    get_word("enc w3", 32'h0c0d0e0f, 4'hf, 1'b0, 0);
    chk("enc wait_tag ready", bus.tag_ready_o, 1'b1);
    chk("enc wait_tag no valid", bus.out_valid_o, 1'b0);
    send_tag(tag_a, '0);
    get_word("enc t0", 32'ha0a1a2a3, 4'hf, 1'b0, 0);
    get_word("enc t1", 32'ha4a5a6a7, 4'hf, 1'b0, 0);
    get_word("enc t2", 32'ha8a9aaab, 4'hf, 1'b0, 0);
    get_word("enc t3", 32'hacadaeaf, 4'hf, 1'b1, 0);
    chk("enc done", bus.done_o, 1'b1);
    chk("enc tag_ok", bus.tag_ok_o, 1'b0);
    chk("enc idle", bus.blk_ready_o, 1'b1);
    step();
    chk("enc done pulse", bus.done_o, 1'b0);

    // Decrypt, 5-byte last block with junk padding, tag match.
    send_blk(128'h1112131415ffffffffffffffffffffff, 5'd5, 1'b1, 1'b1);
    get_word("dec5 w0", 32'h11121314, 4'hf, 1'b0, 0);
    get_word("dec5 w1", 32'h15000000, 4'h8, 1'b1, 0);
    send_tag(tag_b, tag_b);
    chk("dec5 done", bus.done_o, 1'b1);
    chk("dec5 tag_ok", bus.tag_ok_o, 1'b1);
    chk("dec5 no tag words", bus.out_valid_o, 1'b0);
    step();
    chk("dec5 done pulse", bus.done_o, 1'b0);
    chk("dec5 tag_ok hold", bus.tag_ok_o, 1'b1);

    // Decrypt, expected tag differs in bit 0.
    send_blk(128'hdeadbeef00000000000000000000000, 5'd4, 1'b1, 1'b1);
    chk("decbad tag_ok cleared", bus.tag_ok_o, 1'b0);
    get_word("decbad w0", 32'h0deadbee, 4'hf, 1'b1, 0);
    send_tag(tag_b, tag_b ^ 128'h1);
    chk("decbad done", bus.done_o, 1'b1);
    chk("decbad tag_ok", bus.tag_ok_o, 1'b0);
    chk("decbad no tag words", bus.out_valid_o, 1'b0);
    step();
    chk("decbad idle valid", bus.out_valid_o, 1'b0);

    // Random stalls across three decrypt blocks: 16, 16, 7 bytes.
    send_blk(128'h202122232425262728292a2b2c2d2e2f, 5'd16, 1'b0, 1'b1);
    get_word("st b0w0", 32'h20212223, 4'hf, 1'b0, $urandom_range(0, 2));
    get_word("st b0w1", 32'h24252627, 4'hf, 1'b0, $urandom_range(0, 2));
    get_word("st b0w2", 32'h28292a2b, 4'hf, 1'b0, $urandom_range(0, 2));
    get_word("st b0w3", 32'h2c2d2e2f, 4'hf, 1'b0, $urandom_range(0, 2));
    chk("st b0 drained", bus.blk_ready_o, 1'b1);
    send_blk(128'h303132333435363738393a3b3c3d3e3f, 5'd16, 1'b0, 1'b1);
    get_word("st b1w0", 32'h30313233, 4'hf, 1'b0, $urandom_range(0, 2));
    get_word("st b1w1", 32'h34353637, 4'hf, 1'b0, $urandom_range(0, 2));
    get_word("st b1w2", 32'h38393a3b, 4'hf, 1'b0, $urandom_range(0, 2));
    get_word("st b1w3", 32'h3c3d3e3f, 4'hf, 1'b0, $urandom_range(0, 2));
    send_blk(128'h40414243444546aaaaaaaaaaaaaaaaaa, 5'd7, 1'b1, 1'b1);
    get_word("st b2w0", 32'h40414243, 4'hf, 1'b0, $urandom_range(1, 2));
    get_word("st b2w1", 32'h44454600, 4'he, 1'b1, $urandom_range(1, 2));
    chk("st wait_tag", bus.tag_ready_o, 1'b1);
    send_tag(tag_a, tag_a);
    chk("st done", bus.done_o, 1'b1);
    chk("st tag_ok", bus.tag_ok_o, 1'b1);

    // Reset clears a held tag_ok.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2 tag_ok", bus.tag_ok_o, 1'b0);

    // Encrypt: clamped count (20->16), empty non-last, empty last.
    send_blk(128'h505152535455565758595a5b5c5d5e5f, 5'd20, 1'b0, 1'b0);
    get_word("cl w0", 32'h50515253, 4'hf, 1'b0, 0);
    get_word("cl w1", 32'h54555657, 4'hf, 1'b0, 0);
    get_word("cl w2", 32'h58595a5b, 4'hf, 1'b0, 0);
    get_word("cl w3", 32'h5c5d5e5f, 4'hf, 1'b0, 0);
    chk("cl back idle", bus.blk_ready_o, 1'b1);
    send_blk(128'hffffffffffffffffffffffffffffffff, 5'd0, 1'b0, 1'b0);
    chk("empty nonlast idle", bus.blk_ready_o, 1'b1);
    chk("empty nonlast no valid", bus.out_valid_o, 1'b0);
    send_blk(128'hffffffffffffffffffffffffffffffff, 5'd0, 1'b1, 1'b0);
    chk("empty last wait_tag", bus.tag_ready_o, 1'b1);
    chk("empty last no valid", bus.out_valid_o, 1'b0);
    send_tag(tag_b, '0);
    get_word("em t0", 32'h01234567, 4'hf, 1'b0, 0);
    get_word("em t1", 32'h89abcdef, 4'hf, 1'b0, 0);
    get_word("em t2", 32'hfedcba98, 4'hf, 1'b0, 0);
    get_word("em t3", 32'h76543210, 4'hf, 1'b1, 0);
    chk("em done", bus.done_o, 1'b1);

    // Reset after word 2 of a 16-byte block, then a normal message.
    send_blk(128'h606162636465666768696a6b6c6d6e6f, 5'd16, 1'b1, 1'b1);
    get_word("rs w0", 32'h60616263, 4'hf, 1'b0, 0);
    get_word("rs w1", 32'h64656667, 4'hf, 1'b0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs out_valid", bus.out_valid_o, 1'b0);
    chk("rs blk_ready", bus.blk_ready_o, 1'b1);
    chk("rs tag_ok", bus.tag_ok_o, 1'b0);
    chk("rs tag_ready", bus.tag_ready_o, 1'b0);
    step();
    chk("rs stays quiet", bus.out_valid_o, 1'b0);
    send_blk(128'h7071727374757677ffffffffffffffff, 5'd8, 1'b1, 1'b1);
    get_word("post w0", 32'h70717273, 4'hf, 1'b0, 0);
    get_word("post w1", 32'h74757677, 4'hf, 1'b1, 0);
    send_tag(tag_a, tag_a);
    chk("post done", bus.done_o, 1'b1);
    chk("post tag_ok", bus.tag_ok_o, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
